// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU scheduler: opcodes, data widths
// and scheduler FSM states.
package alu_ctrl_pkg;

  localparam int ALU_DW = 8;
  localparam int ALU_RW = 9;

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_MUL  = 4'd2;
  localparam logic [3:0] ALU_OP_DIV  = 4'd3;
  localparam logic [3:0] ALU_OP_SHL  = 4'd4;
  localparam logic [3:0] ALU_OP_SHR  = 4'd5;
  localparam logic [3:0] ALU_OP_ROL  = 4'd6;
  localparam logic [3:0] ALU_OP_ROR  = 4'd7;
  localparam logic [3:0] ALU_OP_AND  = 4'd8;
  localparam logic [3:0] ALU_OP_OR   = 4'd9;
  localparam logic [3:0] ALU_OP_XOR  = 4'd10;
  localparam logic [3:0] ALU_OP_NOR  = 4'd11;
  localparam logic [3:0] ALU_OP_NAND = 4'd12;
  localparam logic [3:0] ALU_OP_XNOR = 4'd13;
  localparam logic [3:0] ALU_OP_GT   = 4'd14;
  localparam logic [3:0] ALU_OP_EQ   = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

endpackage

// File: rtl/alu_sched_if.sv
// Requester and response handshake bundle between client blocks and alu_sched.
interface alu_sched_if
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [4*NUM_REQ-1:0]      req_op;
  logic [ALU_DW*NUM_REQ-1:0] req_a;
  logic [ALU_DW*NUM_REQ-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [ALU_RW-1:0]         rsp_data;
  logic                      rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward,
// with wrap, from last_i+1.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] req_dbl;

  assign req_dbl = {req_i, req_i};
  assign any_o   = |req_i;

  // Doubling the vector turns the wrap-around search into a linear scan.
  always_comb begin
    int unsigned pos;
    int unsigned idx;
    logic        found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = 0;
    idx     = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      pos = 32'(last_i) + 1 + off;
      if (!found && pos < 2 * NUM_REQ && req_dbl[pos]) begin
        found = 1'b1;
        idx   = (pos >= NUM_REQ) ? pos - NUM_REQ : pos;
        grant_o[idx] = 1'b1;
        idx_o = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler feeding a shared external ALU; returns tagged results.
// Optional ALU_DIVZERO_CHECK_EN flags divide-by-zero as rsp_err with data 9'h1FF.
module alu_sched
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_sched_if.slave        bus,
  output logic [3:0]        alu_sel,
  output logic [ALU_DW-1:0] alu_a,
  output logic [ALU_DW-1:0] alu_b,
  input  logic [ALU_RW-1:0] alu_result
);

  sched_state_e      state_q, state_d;
  logic [ID_W-1:0]   last_q, id_q;
  logic [3:0]        sel_q;
  logic [ALU_DW-1:0] a_q, b_q;
  logic [ALU_RW-1:0] data_q, cap_data;

  logic [NUM_REQ-1:0] grant_oh, ready_w;
  logic [ID_W-1:0]    grant_idx;
  logic               any_req, accept;
  logic [3:0]         op_w;
  logic [ALU_DW-1:0]  a_w, b_w;

  alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i   (bus.req_valid),
    .last_i  (last_q),
    .grant_o (grant_oh),
    .idx_o   (grant_idx),
    .any_o   (any_req)
  );

  always_comb begin
    op_w = '0;
    a_w  = '0;
    b_w  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        op_w = bus.req_op[4*i +: 4];
        a_w  = bus.req_a[ALU_DW*i +: ALU_DW];
        b_w  = bus.req_b[ALU_DW*i +: ALU_DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ready_w = '0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          ready_w = grant_oh;
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q  <= op_w;
        a_q    <= a_w;
        b_q    <= b_w;
        id_q   <= grant_idx;
        last_q <= grant_idx;
      end
      if (state_q == EXEC) data_q <= cap_data;
    end
  end

`ifdef ALU_DIVZERO_CHECK_EN
  logic div_zero, err_q;

  assign div_zero = (sel_q == ALU_OP_DIV) && (b_q == '0);
  assign cap_data = div_zero ? '1 : alu_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_q <= 1'b0;
    else if (state_q == EXEC)  err_q <= div_zero;
  end

  assign bus.rsp_err = err_q;
`else
  assign cap_data    = alu_result;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = ready_w;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign alu_sel       = sel_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;

endmodule
